// File: rtl/fsm_encaixotamento_pkg.sv
// ---------------------------------------------------------------------------
// pkg_encaixotamento
// Shared types and default constants for the boxing stage (fsm_encaixotamento).
// Contents:
//   estado_t                 - 3-bit state encoding of the boxing FSM
//   BOTTLES_PER_BOX_DFLT     - slots in one box
//   DEPOSIT_CYCLES_DFLT      - gripper-active time per bottle (clk cycles)
//   CLOSE_CYCLES_DFLT        - box-closer-active time (clk cycles)
//   TIMER_W_DFLT             - timer width able to hold the longest duration
// ---------------------------------------------------------------------------
package pkg_encaixotamento;

    typedef enum logic [2:0] {
        AGUARDA_CAIXA   = 3'd0,
        OCIOSO          = 3'd1,
        DEPOSITAR       = 3'd2,
        CONCLUIR        = 3'd3,
        FECHAR          = 3'd4,
        AGUARDA_REMOCAO = 3'd5
    } estado_t;

    localparam int BOTTLES_PER_BOX_DFLT = 12;
    localparam int DEPOSIT_CYCLES_DFLT  = 50_000_000;
    localparam int CLOSE_CYCLES_DFLT    = 100_000_000;
    localparam int TIMER_W_DFLT         = 27;

endpackage

// File: rtl/fsm_encaixotamento_if.sv
// ---------------------------------------------------------------------------
// fsm_encaixotamento_if
// Command/done handshake between fsm_mestre (master) and the boxing FSM (slave).
// Signals:
//   cmd_depositar     master -> slave  level: approved bottle at final position
//   pronto            slave -> master  idle with a box present, can accept
//   tarefa_concluida  slave -> master  one-cycle pulse: deposit finished
// ---------------------------------------------------------------------------
interface fsm_encaixotamento_if;

    logic cmd_depositar;
    logic pronto;
    logic tarefa_concluida;

    modport master (
        output cmd_depositar,
        input  pronto,
        input  tarefa_concluida
    );

    modport slave (
        input  cmd_depositar,
        output pronto,
        output tarefa_concluida
    );

endinterface

// File: rtl/fsm_encaixotamento_temporizador_ciclos.sv
// ---------------------------------------------------------------------------
// temporizador_ciclos
// Loadable down-counter used to time the gripper and box-closer actions.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   load         load load_value this cycle (has priority over counting)
//   load_value   value to load
//   enable       count down when high (tied to ~pausa, so a pause freezes it)
//   zero         high while the counter holds 0
// The counter saturates at 0, so an idle timer stays quiet.
// ---------------------------------------------------------------------------
module temporizador_ciclos #(
    parameter int TIMER_W = 27
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    // Load wins over counting; counting stops at 0 and while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fsm_encaixotamento.sv
// ---------------------------------------------------------------------------
// fsm_encaixotamento
// Boxing stage: deposits each approved bottle into a box with a timed gripper
// action, closes the box after the last slot, pulses caixa_completa for the
// dozen counter, then waits for the operator to swap the box.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   handshake (slave)   cmd_depositar in / pronto, tarefa_concluida out
//   sensor_caixa        1 = empty/partial box under the gripper
//   pausa               global pause, freezes timers and holds the state
//   garra_ativa         gripper actuator
//   fechador_ativo      box-closer actuator
//   caixa_completa      one-cycle pulse: box closed
//   erro_caixa          one-cycle pulse: partially filled box removed
//   garrafas_na_caixa   bottles currently in the box
// ---------------------------------------------------------------------------
module fsm_encaixotamento
    import pkg_encaixotamento::*;
#(
    parameter int BOTTLES_PER_BOX = BOTTLES_PER_BOX_DFLT,
    parameter int DEPOSIT_CYCLES  = DEPOSIT_CYCLES_DFLT,
    parameter int CLOSE_CYCLES    = CLOSE_CYCLES_DFLT,
    parameter int TIMER_W         = TIMER_W_DFLT
) (
    input  logic                   clk,
    input  logic                   reset,
    fsm_encaixotamento_if.slave    handshake,
    input  logic                   sensor_caixa,
    input  logic                   pausa,
    output logic                   garra_ativa,
    output logic                   fechador_ativo,
    output logic                   caixa_completa,
    output logic                   erro_caixa,
    output logic [3:0]             garrafas_na_caixa
);

    // The timer is loaded with N-1 and the state leaves on the unpaused cycle
    // in which it reads 0, which gives exactly N active cycles.
    localparam logic [TIMER_W-1:0] DEPOSIT_LOAD = TIMER_W'(DEPOSIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LOAD   = TIMER_W'(CLOSE_CYCLES - 1);
    localparam logic [3:0]         BOX_FULL     = 4'(BOTTLES_PER_BOX);

    estado_t            state;
    estado_t            next_state;
    logic [3:0]         count;
    logic [3:0]         count_inc;
    logic               armed;
    logic               accept;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;
    logic               timer_expired;
    logic               caixa_completa_q;
    logic               erro_caixa_q;

    temporizador_ciclos #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (~pausa),
        .zero       (timer_zero)
    );

    assign count_inc     = count + 4'd1;
    assign timer_expired = timer_zero & ~pausa;
    assign accept        = (state == OCIOSO) && sensor_caixa &&
                           handshake.cmd_depositar && armed;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AGUARDA_CAIXA;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, plus the timer load requests made on state entry.
    // A removed box only matters in OCIOSO; during the deposit it is ignored
    // so a bottle already in the gripper always finishes.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = DEPOSIT_LOAD;
        unique case (state)
            AGUARDA_CAIXA: begin
                if (sensor_caixa) begin
                    next_state = OCIOSO;
                end
            end
            OCIOSO: begin
                if (!sensor_caixa) begin
                    next_state = AGUARDA_CAIXA;
                end else if (accept) begin
                    next_state  = DEPOSITAR;
                    timer_load  = 1'b1;
                    timer_value = DEPOSIT_LOAD;
                end
            end
            DEPOSITAR: begin
                if (timer_expired) begin
                    next_state = CONCLUIR;
                end
            end
            CONCLUIR: begin
                if (count_inc == BOX_FULL) begin
                    next_state  = FECHAR;
                    timer_load  = 1'b1;
                    timer_value = CLOSE_LOAD;
                end else begin
                    next_state = OCIOSO;
                end
            end
            FECHAR: begin
                if (timer_expired) begin
                    next_state = AGUARDA_REMOCAO;
                end
            end
            AGUARDA_REMOCAO: begin
                if (!sensor_caixa) begin
                    next_state = AGUARDA_CAIXA;
                end
            end
            default: begin
                next_state = AGUARDA_CAIXA;
            end
        endcase
    end

    // Bottle count, the re-arm flag for the level command, and the registered
    // box-complete / box-error pulses. The pulses land in the first cycle of
    // the following state, alongside the cleared count, so they can never
    // overlap each other or the CONCLUIR pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count            <= 4'd0;
            armed            <= 1'b1;
            caixa_completa_q <= 1'b0;
            erro_caixa_q     <= 1'b0;
        end else begin
            caixa_completa_q <= (state == FECHAR) && timer_expired;
            erro_caixa_q     <= (state == OCIOSO) && !sensor_caixa && (count != 4'd0);

            if (!handshake.cmd_depositar) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            if (state == CONCLUIR) begin
                count <= count_inc;
            end else if ((state == FECHAR) && timer_expired) begin
                count <= 4'd0;
            end else if ((state == OCIOSO) && !sensor_caixa) begin
                count <= 4'd0;
            end
        end
    end

    // Moore outputs; actuators drop while paused and come back on release.
    always_comb begin
        garra_ativa                = (state == DEPOSITAR) && !pausa;
        fechador_ativo             = (state == FECHAR) && !pausa;
        handshake.pronto           = (state == OCIOSO);
        handshake.tarefa_concluida = (state == CONCLUIR);
        caixa_completa             = caixa_completa_q;
        erro_caixa                 = erro_caixa_q;
        garrafas_na_caixa          = count;
    end

endmodule

// File: tb/tb_fsm_encaixotamento.sv
// ---------------------------------------------------------------------------
// tb_fsm_encaixotamento
// Directed, self-checking bench for fsm_encaixotamento with
// BOTTLES_PER_BOX=12, DEPOSIT_CYCLES=4, CLOSE_CYCLES=6.
// ---------------------------------------------------------------------------
module tb_fsm_encaixotamento;

    logic       clk;
    logic       reset;
    logic       sensor_caixa;
    logic       pausa;
    logic       garra_ativa;
    logic       fechador_ativo;
    logic       caixa_completa;
    logic       erro_caixa;
    logic [3:0] garrafas_na_caixa;

    int errors;
    int checks;

    fsm_encaixotamento_if hs_if ();

    fsm_encaixotamento #(
        .BOTTLES_PER_BOX (12),
        .DEPOSIT_CYCLES  (4),
        .CLOSE_CYCLES    (6),
        .TIMER_W         (27)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .handshake         (hs_if),
        .sensor_caixa      (sensor_caixa),
        .pausa             (pausa),
        .garra_ativa       (garra_ativa),
        .fechador_ativo    (fechador_ativo),
        .caixa_completa    (caixa_completa),
        .erro_caixa        (erro_caixa),
        .garrafas_na_caixa (garrafas_na_caixa)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command pulse from OCIOSO and run until tarefa_concluida is seen.
    // lat counts clocks from acceptance to the completion pulse; garra_high and
    // garra_paused count gripper-active cycles outside and inside the pause.
    task automatic run_deposit(input int pause_at, input int pause_len,
                               output int lat, output int garra_high,
                               output int garra_paused);
        lat          = 0;
        garra_high   = 0;
        garra_paused = 0;
        hs_if.cmd_depositar = 1'b1;
        tick();
        hs_if.cmd_depositar = 1'b0;
        while (!hs_if.tarefa_concluida && lat < 50) begin
            pausa = (lat >= pause_at) && (lat < pause_at + pause_len);
            #1;
            if (garra_ativa) begin
                if (pausa) garra_paused++;
                else       garra_high++;
            end
            tick();
            lat++;
        end
        pausa = 1'b0;
        checks++;
        if (lat >= 50) begin
            errors++;
            $display("[TB] FAIL deposit_timeout: actual lat=%0d required completion within 50", lat);
        end
    endtask

    // Perform n plain deposits, ending back in OCIOSO after each.
    task automatic fill(input int n);
        int lat, gh, gp;
        for (int i = 0; i < n; i++) begin
            run_deposit(0, 0, lat, gh, gp);
            tick();
        end
    endtask

    task automatic test_reset();
        reset               = 1'b1;
        sensor_caixa        = 1'b0;
        pausa               = 1'b0;
        hs_if.cmd_depositar = 1'b0;
        tick();
        tick();
        checks++;
        if ({garra_ativa, fechador_ativo, hs_if.pronto, hs_if.tarefa_concluida,
             caixa_completa, erro_caixa} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: actual=%b required=000000",
                     {garra_ativa, fechador_ativo, hs_if.pronto, hs_if.tarefa_concluida,
                      caixa_completa, erro_caixa});
        end
        checks++;
        if (garrafas_na_caixa !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: actual=%0d required=0", garrafas_na_caixa);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (hs_if.pronto !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pronto_no_box: actual=%b required=0", hs_if.pronto);
        end
    endtask

    task automatic test_single_deposit();
        int lat, gh, gp;
        sensor_caixa = 1'b1;
        tick();
        checks++;
        if (hs_if.pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pronto_before_cmd: actual=%b required=1", hs_if.pronto);
        end
        run_deposit(0, 0, lat, gh, gp);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL deposit_latency: actual=%0d required=4", lat);
        end
        checks++;
        if (gh !== 4) begin
            errors++;
            $display("[TB] FAIL garra_cycles: actual=%0d required=4", gh);
        end
        checks++;
        if (garra_ativa !== 1'b0 || garrafas_na_caixa !== 4'd0) begin
            errors++;
            $display("[TB] FAIL concluir_cycle: actual garra=%b count=%0d required garra=0 count=0",
                     garra_ativa, garrafas_na_caixa);
        end
        tick();
        checks++;
        if (hs_if.tarefa_concluida !== 1'b0 || garrafas_na_caixa !== 4'd1 || hs_if.pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_deposit: actual tarefa=%b count=%0d pronto=%b required 0/1/1",
                     hs_if.tarefa_concluida, garrafas_na_caixa, hs_if.pronto);
        end
    endtask

    task automatic test_held_command();
        int pulses;
        int n;
        pulses = 0;
        hs_if.cmd_depositar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_if.tarefa_concluida) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL held_cmd_pulses: actual=%0d required=1", pulses);
        end
        checks++;
        if (garrafas_na_caixa !== 4'd2 || garra_ativa !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_cmd_count: actual count=%0d garra=%b required count=2 garra=0",
                     garrafas_na_caixa, garra_ativa);
        end
        hs_if.cmd_depositar = 1'b0;
        tick();
        hs_if.cmd_depositar = 1'b1;
        tick();
        checks++;
        if (garra_ativa !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rearm_accept: actual garra=%b required=1", garra_ativa);
        end
        hs_if.cmd_depositar = 1'b0;
        n = 0;
        while (!hs_if.tarefa_concluida && n < 50) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (garrafas_na_caixa !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rearm_count: actual=%0d required=3", garrafas_na_caixa);
        end
    endtask

    task automatic test_full_box();
        int lat, gh, gp;
        int fc, n;
        fill(8);
        run_deposit(0, 0, lat, gh, gp);
        checks++;
        if (garrafas_na_caixa !== 4'd11) begin
            errors++;
            $display("[TB] FAIL before_last: actual=%0d required=11", garrafas_na_caixa);
        end
        tick();
        checks++;
        if (garrafas_na_caixa !== 4'd12 || fechador_ativo !== 1'b1 || hs_if.pronto !== 1'b0) begin
            errors++;
            $display("[TB] FAIL box_full: actual count=%0d fechador=%b pronto=%b required 12/1/0",
                     garrafas_na_caixa, fechador_ativo, hs_if.pronto);
        end
        fc = 0;
        n  = 0;
        while (!caixa_completa && n < 50) begin
            if (fechador_ativo) fc++;
            tick();
            n++;
        end
        checks++;
        if (fc !== 6 || n !== 6) begin
            errors++;
            $display("[TB] FAIL close_time: actual fechador=%0d wait=%0d required 6/6", fc, n);
        end
        checks++;
        if (garrafas_na_caixa !== 4'd0 || hs_if.pronto !== 1'b0 || fechador_ativo !== 1'b0 ||
            hs_if.tarefa_concluida !== 1'b0 || erro_caixa !== 1'b0) begin
            errors++;
            $display("[TB] FAIL box_closed: actual count=%0d pronto=%b fechador=%b tarefa=%b erro=%b required 0/0/0/0/0",
                     garrafas_na_caixa, hs_if.pronto, fechador_ativo, hs_if.tarefa_concluida, erro_caixa);
        end
        tick();
        checks++;
        if (caixa_completa !== 1'b0 || hs_if.pronto !== 1'b0) begin
            errors++;
            $display("[TB] FAIL complete_one_pulse: actual caixa=%b pronto=%b required 0/0",
                     caixa_completa, hs_if.pronto);
        end
        sensor_caixa = 1'b0;
        tick();
        sensor_caixa = 1'b1;
        tick();
        checks++;
        if (hs_if.pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL new_box_pronto: actual=%b required=1", hs_if.pronto);
        end
    endtask

    task automatic test_pause();
        int lat, gh, gp;
        run_deposit(1, 3, lat, gh, gp);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("[TB] FAIL pause_latency: actual=%0d required=7", lat);
        end
        checks++;
        if (gh !== 4 || gp !== 0) begin
            errors++;
            $display("[TB] FAIL pause_garra: actual high=%0d paused_high=%0d required 4/0", gh, gp);
        end
        tick();
        checks++;
        if (garrafas_na_caixa !== 4'd1) begin
            errors++;
            $display("[TB] FAIL pause_count: actual=%0d required=1", garrafas_na_caixa);
        end
    endtask

    task automatic test_box_removed();
        fill(4);
        checks++;
        if (garrafas_na_caixa !== 4'd5) begin
            errors++;
            $display("[TB] FAIL partial_count: actual=%0d required=5", garrafas_na_caixa);
        end
        sensor_caixa = 1'b0;
        tick();
        checks++;
        if (erro_caixa !== 1'b1 || garrafas_na_caixa !== 4'd0 || hs_if.pronto !== 1'b0 ||
            caixa_completa !== 1'b0 || hs_if.tarefa_concluida !== 1'b0) begin
            errors++;
            $display("[TB] FAIL removal_error: actual erro=%b count=%0d pronto=%b caixa=%b tarefa=%b required 1/0/0/0/0",
                     erro_caixa, garrafas_na_caixa, hs_if.pronto, caixa_completa, hs_if.tarefa_concluida);
        end
        tick();
        checks++;
        if (erro_caixa !== 1'b0 || hs_if.pronto !== 1'b0) begin
            errors++;
            $display("[TB] FAIL removal_pulse_width: actual erro=%b pronto=%b required 0/0",
                     erro_caixa, hs_if.pronto);
        end
        sensor_caixa = 1'b1;
        tick();
        checks++;
        if (hs_if.pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL box_returned: actual pronto=%b required=1", hs_if.pronto);
        end
    endtask

    task automatic test_reset_in_close();
        int lat, gh, gp;
        int seen;
        fill(11);
        run_deposit(0, 0, lat, gh, gp);
        tick();
        tick();
        tick();
        checks++;
        if (fechador_ativo !== 1'b1 || garrafas_na_caixa !== 4'd12) begin
            errors++;
            $display("[TB] FAIL in_fechar: actual fechador=%b count=%0d required 1/12",
                     fechador_ativo, garrafas_na_caixa);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({garra_ativa, fechador_ativo, hs_if.pronto, hs_if.tarefa_concluida,
             caixa_completa, erro_caixa} !== 6'b0 || garrafas_na_caixa !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_close: actual outs=%b count=%0d required 000000/0",
                     {garra_ativa, fechador_ativo, hs_if.pronto, hs_if.tarefa_concluida,
                      caixa_completa, erro_caixa}, garrafas_na_caixa);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (caixa_completa) seen++;
        end
        checks++;
        if (seen !== 0 || hs_if.pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_complete_after_reset: actual pulses=%0d pronto=%b required 0/1",
                     seen, hs_if.pronto);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_deposit();
        test_held_command();
        test_full_box();
        test_pause();
        test_box_removed();
        test_reset_in_close();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_encaixotamento.md
Name: fsm_encaixotamento

Overview:
Downstream stage after the final-position conveyor move: loads each approved bottle into a 12-slot box at the end of the line. It runs a timed gripper deposit per bottle, closes the box after the last slot, and pulses a box-complete signal that drives the dozen counter. It then waits for the operator to swap the box. It uses the same command/done handshake as the other slave FSMs under fsm_mestre.

Parameters:
BOTTLES_PER_BOX, 12, slots per box (range 2..15)
DEPOSIT_CYCLES, 50_000_000, gripper-active duration per bottle (clk cycles, >=1)
CLOSE_CYCLES, 100_000_000, box-closer-active duration (clk cycles, >=1)
TIMER_W, 27, timer width; must hold max(DEPOSIT_CYCLES, CLOSE_CYCLES)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
cmd_depositar  in  1  level from master: an approved bottle is at the final position
sensor_caixa  in  1  1 = empty/partial box present under gripper
pausa  in  1  global pause (driven by the cork-empty alarm): freezes timers
garra_ativa  out  1  gripper actuator LED
fechador_ativo  out  1  box-closer actuator LED
pronto  out  1  1 = idle with a box present, can accept a deposit
tarefa_concluida  out  1  one-cycle pulse: deposit finished
caixa_completa  out  1  one-cycle pulse: box closed; connects to the dozen counter's increment input
erro_caixa  out  1  one-cycle pulse: box removed while partially filled
garrafas_na_caixa  out  4  bottles currently in the box

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. It is sampled on the clk rising edge and overrides everything, including mid-operation.
- Reset state: AGUARDA_CAIXA. Reset values:
  - all outputs 0
  - count 0
  - timer 0
  - armed flag 1
- States: AGUARDA_CAIXA, OCIOSO, DEPOSITAR, CONCLUIR, FECHAR, AGUARDA_REMOCAO.
- AGUARDA_CAIXA: pronto=0. sensor_caixa=1 → OCIOSO.
- OCIOSO: pronto=1.
  - cmd_depositar=1, armed=1 and sensor_caixa=1 → DEPOSITAR. Timer loads DEPOSIT_CYCLES; armed clears.
  - sensor_caixa=0 with count>0 → AGUARDA_CAIXA. erro_caixa pulses and count clears.
  - sensor_caixa=0 with count=0 → AGUARDA_CAIXA silently.
- Armed flag: set on any cycle where cmd_depositar=0. A held command therefore never triggers a second deposit.
- DEPOSITAR: garra_ativa=1 unless pausa=1.
  - Timer decrements only when pausa=0.
  - The cycle the timer reaches 0 → CONCLUIR.
  - sensor_caixa is ignored here; the deposit always completes.
- CONCLUIR (one cycle): tarefa_concluida=1 and count increments.
  - New count == BOTTLES_PER_BOX → FECHAR, timer loads CLOSE_CYCLES.
  - Otherwise → OCIOSO.
- Deposit latency: cmd accepted at edge N. garra_ativa is high for DEPOSIT_CYCLES cycles starting at N+1 (no pause). tarefa_concluida is high in cycle N+1+DEPOSIT_CYCLES.
- FECHAR: fechador_ativo=1 unless pausa=1. Timer decrements only when pausa=0.
  - At expiry: caixa_completa pulses for exactly one cycle, count clears to 0, → AGUARDA_REMOCAO.
- AGUARDA_REMOCAO: pronto=0. sensor_caixa=0 → AGUARDA_CAIXA. A new box needs sensor 1→0→1.
- garrafas_na_caixa: equals count, range 0..BOTTLES_PER_BOX. It never exceeds BOTTLES_PER_BOX and never wraps.
- Exclusivity: tarefa_concluida, caixa_completa and erro_caixa are never high in the same cycle.
- Commands outside OCIOSO are ignored, not queued. The master must wait for pronto.
- Pause: pausa stretches timing cycle-for-cycle and holds the state. Actuator outputs drop during pause and resume on release. Pulses are never lost or duplicated.

Decomposition:
- Package pkg_encaixotamento holds:
  - the state enum (3-bit encoding, the six states above)
  - default constants for BOTTLES_PER_BOX, DEPOSIT_CYCLES and CLOSE_CYCLES
- One sub-module, temporizador_ciclos:
  - inputs: load, load value, enable (= ~pausa)
  - outputs: zero flag
  - timer width is TIMER_W
- One instance of temporizador_ciclos is shared by DEPOSITAR and FECHAR.
- Instantiated structurally in projeto_vinho_top alongside the other slave FSMs.

Test Plan:
Bench parameters: BOTTLES_PER_BOX=12, DEPOSIT_CYCLES=4, CLOSE_CYCLES=6.
1. Reset, then sensor_caixa=1, then one cmd_depositar pulse → pronto=1 before the command; garra_ativa high for 4 cycles; tarefa_concluida one pulse 5 cycles after acceptance; garrafas_na_caixa=1.
2. cmd_depositar held high for 20 cycles → exactly one deposit. A second deposit starts only after cmd goes low then high.
3. 12 deposits → after the 12th, fechador_ativo high for 6 cycles, then caixa_completa one pulse, count=0, pronto=0. sensor_caixa 1→0→1 → pronto=1.
4. pausa=1 for 3 cycles during a deposit → garra_ativa low during the pause; tarefa_concluida delayed by exactly 3 cycles; count still +1.
5. count=5, sensor_caixa drops in OCIOSO → erro_caixa one pulse, count=0, pronto=0 until the box returns.
6. reset asserted in FECHAR at count=12 → next cycle: AGUARDA_CAIXA, all outputs 0, no caixa_completa pulse.
